// File: rtl/adc_spi_responder_if.sv
// Four-wire SPI link between the FPGA's SPI master and the emulated serial ADC.
// The master drives clock, select and data in; the responder drives data out.
interface adc_spi_responder_if;
    logic sclk;
    logic cs;
    logic din;
    logic dout;

    modport master (
        output sclk,
        output cs,
        output din,
        input  dout
    );

    modport slave (
        input  sclk,
        input  cs,
        input  din,
        output dout
    );
endinterface

// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit serial ADC: captures the channel
// address from each frame and returns the sample of the previously addressed channel.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    adc_spi_responder_if.slave       spi,
    input  logic [95:0]              ch_data,
    output logic [2:0]               cur_addr,
    output logic                     frame_done,
    output logic                     frame_err
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [15:0] shift_reg, shift_next;
    logic [2:0]  addr_cap_reg, addr_cap_next;
    logic [2:0]  cur_addr_reg, cur_addr_next;
    logic        dout_reg, dout_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;

    // Pin bundle ordered {sclk, cs, din}; all three share one synchronizer chain.
    logic [2:0]  pins;
    logic [2:0]  synced;
    logic [2:0]  hist_reg;

    assign pins = {spi.sclk, spi.cs, spi.din};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) q <= 3'b000;
                    else       q <= pins;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (reset) q <= 3'b000;
                    else       q <= g_sync[gi-1].q;
                end
            end
        end
    endgenerate

    assign synced = g_sync[SYNC_STAGES-1].q;

    // Zero reset of the chain means a master still holding cs low across a
    // reset produces no falling edge, so an interrupted frame stays silent.
    always_ff @(posedge clk) begin
        if (reset) hist_reg <= 3'b000;
        else       hist_reg <= synced;
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;

    assign sclk_rise = synced[2] & ~hist_reg[2];
    assign sclk_fall = ~synced[2] & hist_reg[2];
    assign cs_rise   = synced[1] & ~hist_reg[1];
    assign cs_fall   = ~synced[1] & hist_reg[1];
    assign din_s     = synced[0];

    logic [11:0] ch_sel;
    always_comb begin
        ch_sel = ch_data[12*cur_addr_reg +: 12];
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= 5'd0;
            shift_reg    <= 16'd0;
            addr_cap_reg <= 3'd0;
            cur_addr_reg <= 3'd0;
            dout_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            shift_reg    <= shift_next;
            addr_cap_reg <= addr_cap_next;
            cur_addr_reg <= cur_addr_next;
            dout_reg     <= dout_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output logic; cs edges take priority over sclk edges.
    always_comb begin
        count_next    = count_reg;
        shift_next    = shift_reg;
        addr_cap_next = addr_cap_reg;
        cur_addr_next = cur_addr_reg;
        dout_next     = dout_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                dout_next = 1'b0;
                if (cs_fall) begin
                    shift_next = {4'b0000, ch_sel};
                    count_next = 5'd0;
                    dout_next  = 1'b0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    dout_next = 1'b0;
                    if (count_reg == 5'd16) begin
                        cur_addr_next = addr_cap_reg;
                        done_next     = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (cs_fall) begin
                    dout_next = dout_reg;
                end else if (sclk_rise) begin
                    if (count_reg < 5'd16) begin
                        count_next = count_reg + 5'd1;
                        // Rising edges 3..5 carry ADD2..ADD0
                        if (count_reg == 5'd2) addr_cap_next[2] = din_s;
                        if (count_reg == 5'd3) addr_cap_next[1] = din_s;
                        if (count_reg == 5'd4) addr_cap_next[0] = din_s;
                    end
                end else if (sclk_fall) begin
                    if (count_reg >= 5'd1 && count_reg <= 5'd15) begin
                        shift_next = {shift_reg[14:0], 1'b0};
                        dout_next  = shift_reg[14];
                    end else if (count_reg == 5'd16) begin
                        dout_next = 1'b0;
                    end
                end
            end
            default: dout_next = 1'b0;
        endcase
    end

    assign spi.dout   = dout_reg;
    assign cur_addr   = cur_addr_reg;
    assign frame_done = done_reg;
    assign frame_err  = err_reg;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder: a behavioural SPI master plus a
// channel/address model predicts every returned frame and status pulse.
module tb_adc_spi_responder;
    localparam int SS   = 2;
    localparam int HALF = 5;
    localparam int TCLK = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] ch_data;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic        frame_err;

    adc_spi_responder_if spi();

    adc_spi_responder #(.SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi),
        .ch_data    (ch_data),
        .cur_addr   (cur_addr),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #(TCLK/2) clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int  done_cnt = 0;
    int  err_cnt  = 0;
    time done_t   = 0;
    time err_t    = 0;
    time cs_rise_t;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_t   = $time;
        end
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            err_t   = $time;
        end
    end

    // Reference model: channel samples and the address the next frame returns
    logic [11:0] m_ch [8];
    logic [2:0]  m_addr;

    function automatic logic [95:0] pack_ch();
        logic [95:0] p;
        for (int i = 0; i < 8; i++) p[12*i +: 12] = m_ch[i];
        return p;
    endfunction

    function automatic logic [15:0] exp_word();
        return {4'b0000, m_ch[m_addr]};
    endfunction

    function automatic logic [31:0] prefix_mask(input int n);
        logic [31:0] ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

    function automatic logic [15:0] mk_tx(input logic [2:0] a);
        return {2'($urandom), a, 11'($urandom)};
    endfunction

    task automatic randomize_ch();
        for (int i = 0; i < 8; i++) m_ch[i] = 12'($urandom);
        ch_data = pack_ch();
    endtask

    // One master frame: sclk idles high, din changes on falling sclk, dout is
    // sampled just before each rising edge. rx[31-(k-1)] holds the bit read at rise k.
    task automatic spi_frame(input logic [15:0] tx, input int nclk,
                             output logic [31:0] rx, output logic [1:0] lat_obs,
                             input int reset_at = 0, input int change_at = 0,
                             input logic [95:0] change_val = '0);
        rx      = '0;
        lat_obs = 2'b00;
        @(negedge clk);
        spi.cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            spi.sclk = 1'b0;
            spi.din  = (k <= 16) ? tx[16-k] : 1'($urandom);
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (k == 5 && c == SS)     lat_obs[1] = spi.dout;
                if (k == 5 && c == SS + 1) lat_obs[0] = spi.dout;
            end
            rx[32-k] = spi.dout;
            spi.sclk = 1'b1;
            if (k == change_at) ch_data = change_val;
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        spi.cs    = 1'b1;
        cs_rise_t = $time;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        spi.sclk = 1'b1; spi.cs = 1'b1; spi.din = 1'b0;
        randomize_ch();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_addr = 3'd0;
        checks++;
        if (spi.dout !== 1'b0 || cur_addr !== 3'd0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: dout=%b cur_addr=%0d done=%b err=%b, required 0/0/0/0",
                     spi.dout, cur_addr, frame_done, frame_err);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (spi.dout !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: dout=%b done=%b err=%b, required 0/0/0", spi.dout, frame_done, frame_err);
        end
        $display("test_reset: dout=%b cur_addr=%0d", spi.dout, cur_addr);
    endtask

    task automatic test_basic_frame();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp; int d0, e0;
        m_ch[0] = 12'hA5C; ch_data = pack_ch();
        exp = exp_word(); d0 = done_cnt; e0 = err_cnt;
        spi_frame(16'h2800, 16, rx, lat);
        m_addr = 3'd5;
        checks++;
        if (rx[31:16] !== exp) begin
            failures++;
            $display("FAIL basic_word: got %h, required %h", rx[31:16], exp);
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            failures++;
            $display("FAIL basic_pulses: done=%0d err=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (cur_addr !== m_addr) begin
            failures++;
            $display("FAIL basic_addr: got %0d, required %0d", cur_addr, m_addr);
        end
        checks++;
        if (done_t - cs_rise_t != (SS + 1) * TCLK) begin
            failures++;
            $display("FAIL done_latency: got %0t, required %0t", done_t - cs_rise_t, (SS + 1) * TCLK);
        end
        checks++;
        if (lat !== {1'b0, exp[11]}) begin
            failures++;
            $display("FAIL dout_latency: got %b, required %b", lat, {1'b0, exp[11]});
        end
        $display("test_basic_frame: rx=%h cur_addr=%0d", rx[31:16], cur_addr);
    endtask

    task automatic test_second_frame();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp;
        m_ch[5] = 12'h123; ch_data = pack_ch();
        exp = exp_word();
        spi_frame(mk_tx(3'b010), 16, rx, lat);
        m_addr = 3'd2;
        checks++;
        if (rx[31:16] !== exp || exp !== 16'h0123) begin
            failures++;
            $display("FAIL second_word: got %h, required %h", rx[31:16], exp);
        end
        checks++;
        if (cur_addr !== 3'd2) begin
            failures++;
            $display("FAIL second_addr: got %0d, required 2", cur_addr);
        end
        $display("test_second_frame: rx=%h cur_addr=%0d", rx[31:16], cur_addr);
    endtask

    task automatic test_midframe_change();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp; logic [2:0] a;
        m_ch[2] = 12'h0FF; ch_data = pack_ch();
        exp = exp_word();
        m_ch[2] = 12'hFFF;
        a = 3'($urandom);
        spi_frame(mk_tx(a), 16, rx, lat, 0, 8, pack_ch());
        m_addr = a;
        checks++;
        if (rx[31:16] !== 16'h00FF) begin
            failures++;
            $display("FAIL midframe_word: got %h, required %h", rx[31:16], exp);
        end
        $display("test_midframe_change: rx=%h", rx[31:16]);
    endtask

    task automatic test_abort();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp; int d0, e0; logic [2:0] old;
        exp = exp_word(); d0 = done_cnt; e0 = err_cnt; old = m_addr;
        spi_frame(mk_tx(3'b111), 9, rx, lat);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_pulses: done=%0d err=%0d, required 0/1", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (err_t - cs_rise_t != (SS + 1) * TCLK) begin
            failures++;
            $display("FAIL err_latency: got %0t, required %0t", err_t - cs_rise_t, (SS + 1) * TCLK);
        end
        checks++;
        if (cur_addr !== old) begin
            failures++;
            $display("FAIL abort_addr: got %0d, required %0d", cur_addr, old);
        end
        checks++;
        if ((rx & prefix_mask(9)) !== ({exp, 16'h0} & prefix_mask(9))) begin
            failures++;
            $display("FAIL abort_prefix: got %h, required %h", rx & prefix_mask(9), {exp, 16'h0} & prefix_mask(9));
        end
        randomize_ch();
        exp = exp_word();
        spi_frame(mk_tx(old), 16, rx, lat);
        checks++;
        if (rx[31:16] !== exp) begin
            failures++;
            $display("FAIL after_abort_word: got %h, required %h", rx[31:16], exp);
        end
        $display("test_abort: err=%0d cur_addr=%0d next rx=%h", err_cnt - e0, cur_addr, rx[31:16]);
    endtask

    task automatic test_long_frame();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp; int d0;
        randomize_ch();
        exp = exp_word(); d0 = done_cnt;
        spi_frame(mk_tx(3'b011), 20, rx, lat);
        m_addr = 3'd3;
        checks++;
        if (rx[31:12] !== {exp, 4'h0}) begin
            failures++;
            $display("FAIL long_bits: got %h, required %h", rx[31:12], {exp, 4'h0});
        end
        checks++;
        if (done_cnt - d0 != 1 || cur_addr !== 3'd3) begin
            failures++;
            $display("FAIL long_done: done=%0d cur_addr=%0d, required 1/3", done_cnt - d0, cur_addr);
        end
        $display("test_long_frame: rx=%h extra=%h cur_addr=%0d", rx[31:16], rx[15:12], cur_addr);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp; int d0, e0; logic [2:0] a;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(mk_tx(3'b110), 16, rx, lat, 8);
        m_addr = 3'd0;
        checks++;
        if (rx[23:16] !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_dout: got %h, required 00", rx[23:16]);
        end
        checks++;
        if (cur_addr !== 3'd0 || done_cnt != d0 || err_cnt != e0) begin
            failures++;
            $display("FAIL rstmid_state: cur_addr=%0d done=%0d err=%0d, required 0/0/0",
                     cur_addr, done_cnt - d0, err_cnt - e0);
        end
        randomize_ch();
        exp = exp_word();
        a = 3'($urandom);
        spi_frame(mk_tx(a), 16, rx, lat);
        m_addr = a;
        checks++;
        if (rx[31:16] !== exp) begin
            failures++;
            $display("FAIL rstmid_next: got %h, required %h", rx[31:16], exp);
        end
        $display("test_reset_midframe: next rx=%h cur_addr=%0d", rx[31:16], cur_addr);
    endtask

    task automatic test_random();
        logic [31:0] rx; logic [1:0] lat; logic [15:0] exp; int d0, e0, n; logic [2:0] a;
        for (int t = 0; t < 12; t++) begin
            randomize_ch();
            exp = exp_word(); d0 = done_cnt; e0 = err_cnt;
            a = 3'($urandom);
            n = $urandom_range(3, 20);
            spi_frame(mk_tx(a), n, rx, lat);
            if (n >= 16) m_addr = a;
            checks++;
            if ((rx & prefix_mask(n)) !== ({exp, 16'h0} & prefix_mask(n))) begin
                failures++;
                $display("FAIL rand_bits[%0d]: got %h, required %h", t, rx & prefix_mask(n),
                         {exp, 16'h0} & prefix_mask(n));
            end
            checks++;
            if (cur_addr !== m_addr || done_cnt - d0 != (n >= 16 ? 1 : 0) || err_cnt - e0 != (n >= 16 ? 0 : 1)) begin
                failures++;
                $display("FAIL rand_status[%0d]: cur_addr=%0d done=%0d err=%0d, required %0d/%0d/%0d", t,
                         cur_addr, done_cnt - d0, err_cnt - e0, m_addr, (n >= 16 ? 1 : 0), (n >= 16 ? 0 : 1));
            end
            $display("test_random[%0d]: n=%0d rx=%h cur_addr=%0d", t, n, rx[31:16], cur_addr);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ch_data  = '0;
        spi.sclk = 1'b1;
        spi.cs   = 1'b1;
        spi.din  = 1'b0;
        test_reset();
        test_basic_frame();
        test_second_frame();
        test_midframe_change();
        test_abort();
        test_long_frame();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that emulates the 8-channel, 12-bit serial ADC driven by the FPGA's SPI master. It decodes the master's `cs`/`sclk`/`din` frames, captures the 3-bit channel address, and shifts back 16-bit frames carrying the 12-bit sample of the previously addressed channel. It is used for loopback self-test and as the ADC stand-in on the bench. It sits on the same four wires as the real converter, with channel samples supplied in parallel.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `cs`, `din` (≥2).
- `clk`  in  1  responder clock; must be ≥8× the `sclk` frequency.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from master; idles high.
- `cs`  in  1  chip select from master; active low.
- `din`  in  1  master-to-responder serial data, MSB first.
- `dout`  out  1  responder-to-master serial data, MSB first; registered.
- `ch_data`  in  96  channel samples; channel n = `ch_data[12n+11:12n]`.
- `cur_addr`  out  3  channel that the next frame returns.
- `frame_done`  out  1  one-`clk` pulse when a complete 16-bit frame ends.
- `frame_err`  out  1  one-`clk` pulse when `cs` rises before 16 rising `sclk` edges.

## Operation
- `sclk`, `cs`, and `din` each pass through `SYNC_STAGES` flops, plus one history flop for edge detection. All logic below acts on the synchronized signals.
- Reset values: `dout`=0, `cur_addr`=0, `frame_done`=0, `frame_err`=0, state IDLE, bit counter 0, shift register 0, address capture 0.
- **IDLE**: `dout`=0. On a `cs` falling edge:
  - Snapshot shift register = {4'b0000, channel `cur_addr` of `ch_data`}.
  - Clear the bit counter.
  - `dout` ← shift register bit 15 (0).
  - Go to SHIFT.
- **SHIFT**:
  - On a rising `sclk` edge, if count <16: count++ and sample `din`. Rising edges 3, 4, 5 capture ADD2, ADD1, ADD0 (bits DB13..DB11) into the address-capture register.
  - On a falling `sclk` edge, if 1 ≤ count ≤ 15: shift left and drive `dout` ← new bit 15. After falling edge k, `dout` carries frame bit 15−k.
  - The falling edge after rising edge 16 forces `dout`=0.
  - Count saturates at 16. Further `sclk` edges are ignored and `dout` stays 0.
- On a `cs` rising edge in SHIFT:
  - If count==16: `cur_addr` ← address capture, pulse `frame_done`, go to IDLE.
  - If count <16: pulse `frame_err`, leave `cur_addr` unchanged, go to IDLE.
  - In both cases `dout` ← 0.
- The first frame after reset returns channel 0, whatever address is sent in it.
- `ch_data` is sampled only at the `cs` falling edge. Later changes do not affect the current frame.
- A `cs` edge and an `sclk` edge detected in the same `clk` cycle: the `cs` edge wins and the `sclk` edge is discarded.
- A `cs` falling edge while in SHIFT is not possible without a rising edge first. A `cs` rising edge while in IDLE is ignored.
- Asserting `reset` mid-frame returns the block to reset values on the next `clk` edge. The interrupted frame produces no pulse.

## Timing
- `dout` changes exactly `SYNC_STAGES`+1 `clk` cycles after the pin-level `sclk` falling edge. With the default, that is 3 cycles.
- `dout` changes the same `SYNC_STAGES`+1 cycles after the `cs` falling edge.
- The master samples on rising `sclk`. The `sclk` low half-period must therefore be ≥4 `clk` cycles, which gives ≥8 `clk` per `sclk` period.
- `din` is taken from the synchronized sample aligned with the detected rising edge. The master must hold `din` stable for ≥`SYNC_STAGES`+1 `clk` around rising `sclk`.
- `frame_done` / `frame_err` assert `SYNC_STAGES`+1 cycles after the pin-level `cs` rise. `cur_addr` updates in that same cycle.
- `cs` must stay high for ≥2 `clk` between frames.

## Test plan
- Reset, then `ch_data` ch0=0xA5C. Send a 16-clock frame with `din`=0x2800 (ADD=101) → master receives 0x0A5C; `frame_done` pulses once; `cur_addr`=5.
- Set ch5=0x123 and send a second frame with ADD=010 → master receives 0x0123; `cur_addr`=2.
- Change ch2 from 0x0FF to 0xFFF midway through the third frame → master receives 0x00FF.
- Raise `cs` after 9 rising edges with ADD=111 → `frame_err` pulses once; no `frame_done`; `cur_addr` unchanged. The next full frame returns the old channel.
- Send 20 `sclk` cycles in one frame with ADD=011 → bits 17–20 read 0; `frame_done` pulses; `cur_addr`=3.
- Assert `reset` for 1 cycle at rising edge 8 of a frame → `dout`=0, `cur_addr`=0, no pulses. A new full frame then returns ch0.
